// File: rtl/dma_axi_bridge_if.sv
// AXI4 master-side channel bundle (AR/R/AW/W/B) between the DMA bridge and the interconnect.
// The bridge connects through modport master; the memory side or a bench uses modport slave.
interface dma_axi_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   m_araddr;
    logic [7:0]              m_arlen;
    logic [2:0]              m_arsize;
    logic [1:0]              m_arburst;
    logic                    m_arvalid;
    logic                    m_arready;

    logic [DATA_WIDTH-1:0]   m_rdata;
    logic [1:0]              m_rresp;
    logic                    m_rlast;
    logic                    m_rvalid;
    logic                    m_rready;

    logic [ADDR_WIDTH-1:0]   m_awaddr;
    logic [7:0]              m_awlen;
    logic [2:0]              m_awsize;
    logic [1:0]              m_awburst;
    logic                    m_awvalid;
    logic                    m_awready;

    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_wstrb;
    logic                    m_wlast;
    logic                    m_wvalid;
    logic                    m_wready;

    logic [1:0]              m_bresp;
    logic                    m_bvalid;
    logic                    m_bready;

    modport master (
        output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready,
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready,
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/dma_axi_bridge.sv
// Converts DMA engine burst requests into AXI4 read/write bursts; one outstanding burst per direction.
// Optional macro BRIDGE_TIMEOUT_EN adds per-phase watchdogs that abort a stuck burst and set err_status[3].
module dma_axi_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [4:0]            rd_req_len,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [4:0]            wr_req_len,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_last,
    input  logic                  err_clr,
    output logic [3:0]            err_status,
    dma_axi_bridge_if.master      m_axi
);
    localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_AR = 2'd1, RD_DATA = 2'd2} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_AW = 2'd1, WR_DATA = 2'd2, WR_RESP = 2'd3} wr_state_e;

    rd_state_e             rd_state_q, rd_state_d;
    wr_state_e             wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [4:0]            rd_len_q, rd_len_d, wr_len_q, wr_len_d;
    logic [4:0]            rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [3:0]            err_q, err_d;
    logic                  rd_beat_s, wr_beat_s, wr_gen_last_s;
    logic                  rd_len_err_s, rd_resp_err_s, wr_len_err_s, wr_resp_err_s;
    logic                  rd_timeout_s, wr_timeout_s;

    // read FSM next state, request capture and beat accounting
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_addr_d     = rd_addr_q;
        rd_len_d      = rd_len_q;
        rd_cnt_d      = rd_cnt_q;
        rd_beat_s     = 1'b0;
        rd_len_err_s  = 1'b0;
        rd_resp_err_s = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (rd_req_valid) begin
                    rd_addr_d  = rd_req_addr;
                    rd_len_d   = rd_req_len;
                    rd_cnt_d   = 5'd0;
                    rd_state_d = RD_AR;
                end else begin
                    rd_state_d = RD_IDLE;
                end
            end
            RD_AR: begin
                if (m_axi.m_arready) begin
                    rd_state_d = RD_DATA;
                end else begin
                    rd_state_d = RD_AR;
                end
            end
            RD_DATA: begin
                rd_beat_s = m_axi.m_rvalid & rd_ready;
                if (rd_beat_s) begin
                    rd_cnt_d      = rd_cnt_q + 5'd1;
                    rd_resp_err_s = (m_axi.m_rresp != 2'b00);
                    // rlast must coincide exactly with the beat whose index equals the requested len
                    rd_len_err_s  = m_axi.m_rlast ^ (rd_cnt_q == rd_len_q);
                    rd_state_d    = m_axi.m_rlast ? RD_IDLE : RD_DATA;
                end else begin
                    rd_state_d = RD_DATA;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
        if (rd_timeout_s) begin
            rd_state_d = RD_IDLE;
        end else begin
            rd_state_d = rd_state_d;
        end
    end

    assign wr_gen_last_s = (wr_cnt_q == wr_len_q);

    // write FSM next state; W is only forwarded after the AW handshake
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_addr_d     = wr_addr_q;
        wr_len_d      = wr_len_q;
        wr_cnt_d      = wr_cnt_q;
        wr_beat_s     = 1'b0;
        wr_len_err_s  = 1'b0;
        wr_resp_err_s = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_req_valid) begin
                    wr_addr_d  = wr_req_addr;
                    wr_len_d   = wr_req_len;
                    wr_cnt_d   = 5'd0;
                    wr_state_d = WR_AW;
                end else begin
                    wr_state_d = WR_IDLE;
                end
            end
            WR_AW: begin
                if (m_axi.m_awready) begin
                    wr_state_d = WR_DATA;
                end else begin
                    wr_state_d = WR_AW;
                end
            end
            WR_DATA: begin
                wr_beat_s = wr_valid & m_axi.m_wready;
                if (wr_beat_s) begin
                    wr_cnt_d     = wr_cnt_q + 5'd1;
                    wr_len_err_s = wr_last ^ wr_gen_last_s;
                    wr_state_d   = wr_gen_last_s ? WR_RESP : WR_DATA;
                end else begin
                    wr_state_d = WR_DATA;
                end
            end
            WR_RESP: begin
                if (m_axi.m_bvalid) begin
                    wr_resp_err_s = (m_axi.m_bresp != 2'b00);
                    wr_state_d    = WR_IDLE;
                end else begin
                    wr_state_d = WR_RESP;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
        if (wr_timeout_s) begin
            wr_state_d = WR_IDLE;
        end else begin
            wr_state_d = wr_state_d;
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] rd_wd_q, rd_wd_d, wr_wd_q, wr_wd_d;
    logic            rd_phase_hs_s, wr_phase_hs_s;

    // read watchdog: cycles in the current phase without that phase's handshake
    always_comb begin
        case (rd_state_q)
            RD_AR:   rd_phase_hs_s = m_axi.m_arready;
            RD_DATA: rd_phase_hs_s = m_axi.m_rvalid & rd_ready;
            default: rd_phase_hs_s = 1'b0;
        endcase
        rd_timeout_s = 1'b0;
        if ((rd_state_q == RD_IDLE) || rd_phase_hs_s) begin
            rd_wd_d = {WD_W{1'b0}};
        end else if (rd_wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            rd_wd_d      = {WD_W{1'b0}};
            rd_timeout_s = 1'b1;
        end else begin
            rd_wd_d = rd_wd_q + {{(WD_W-1){1'b0}}, 1'b1};
        end
    end

    // write watchdog: same rule over AW, W and B phases
    always_comb begin
        case (wr_state_q)
            WR_AW:   wr_phase_hs_s = m_axi.m_awready;
            WR_DATA: wr_phase_hs_s = wr_valid & m_axi.m_wready;
            WR_RESP: wr_phase_hs_s = m_axi.m_bvalid;
            default: wr_phase_hs_s = 1'b0;
        endcase
        wr_timeout_s = 1'b0;
        if ((wr_state_q == WR_IDLE) || wr_phase_hs_s) begin
            wr_wd_d = {WD_W{1'b0}};
        end else if (wr_wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            wr_wd_d      = {WD_W{1'b0}};
            wr_timeout_s = 1'b1;
        end else begin
            wr_wd_d = wr_wd_q + {{(WD_W-1){1'b0}}, 1'b1};
        end
    end

    // watchdog counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wd_q <= {WD_W{1'b0}};
            wr_wd_q <= {WD_W{1'b0}};
        end else begin
            rd_wd_q <= rd_wd_d;
            wr_wd_q <= wr_wd_d;
        end
    end
`else
    logic [31:0] unused_timeout_cycles_s;
    assign unused_timeout_cycles_s = TIMEOUT_CYCLES;
    assign rd_timeout_s = 1'b0;
    assign wr_timeout_s = 1'b0;
`endif

    // sticky errors: a new event in the same cycle as err_clr keeps its bit set
    always_comb begin
        if (err_clr) begin
            err_d = 4'b0000;
        end else begin
            err_d = err_q;
        end
        err_d = err_d | {rd_timeout_s | wr_timeout_s, rd_len_err_s | wr_len_err_s,
                         wr_resp_err_s, rd_resp_err_s};
    end

    // state, latched request and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_IDLE;
            rd_addr_q  <= {ADDR_WIDTH{1'b0}};
            wr_addr_q  <= {ADDR_WIDTH{1'b0}};
            rd_len_q   <= 5'd0;
            wr_len_q   <= 5'd0;
            rd_cnt_q   <= 5'd0;
            wr_cnt_q   <= 5'd0;
            err_q      <= 4'b0000;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            rd_len_q   <= rd_len_d;
            wr_len_q   <= wr_len_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
        end
    end

    assign rd_req_ready      = ~rst & (rd_state_q == RD_IDLE);
    assign m_axi.m_arvalid   = (rd_state_q == RD_AR);
    assign m_axi.m_araddr    = rd_addr_q;
    assign m_axi.m_arlen     = {3'b000, rd_len_q};
    assign m_axi.m_arsize    = AXSIZE;
    assign m_axi.m_arburst   = 2'b01;
    assign rd_rdata          = m_axi.m_rdata;
    assign rd_valid          = (rd_state_q == RD_DATA) & m_axi.m_rvalid;
    assign rd_last           = (rd_state_q == RD_DATA) & m_axi.m_rlast;
    assign m_axi.m_rready    = (rd_state_q == RD_DATA) & rd_ready;

    assign wr_req_ready      = ~rst & (wr_state_q == WR_IDLE);
    assign m_axi.m_awvalid   = (wr_state_q == WR_AW);
    assign m_axi.m_awaddr    = wr_addr_q;
    assign m_axi.m_awlen     = {3'b000, wr_len_q};
    assign m_axi.m_awsize    = AXSIZE;
    assign m_axi.m_awburst   = 2'b01;
    assign m_axi.m_wdata     = wr_data;
    assign m_axi.m_wstrb     = {(DATA_WIDTH/8){1'b1}};
    assign m_axi.m_wvalid    = (wr_state_q == WR_DATA) & wr_valid;
    assign m_axi.m_wlast     = (wr_state_q == WR_DATA) & wr_gen_last_s;
    assign wr_ready          = (wr_state_q == WR_DATA) & m_axi.m_wready;
    assign m_axi.m_bready    = (wr_state_q == WR_RESP);

    assign err_status        = err_q;
endmodule

// File: tb/tb_dma_axi_bridge.sv
// Randomized self-checking bench: plays DMA engine and AXI memory, compares against burst-level rules.
module tb_dma_axi_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd_req_addr, wr_req_addr, rd_rdata, wr_data;
    logic [4:0]  rd_req_len, wr_req_len;
    logic        rd_req_valid, rd_req_ready, rd_valid, rd_ready, rd_last;
    logic        wr_req_valid, wr_req_ready, wr_valid, wr_ready, wr_last;
    logic        err_clr;
    logic [3:0]  err_status;
    logic [3:0]  exp_err;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    dma_axi_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ax ();

    dma_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready), .rd_rdata(rd_rdata), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_last(rd_last),
        .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_req_valid(wr_req_valid),
        .wr_req_ready(wr_req_ready), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_last(wr_last),
        .err_clr(err_clr), .err_status(err_status),
        .m_axi(ax)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One read burst; the memory sends last_at+1 beats with rlast on beat last_at.
    task automatic do_read(input logic [31:0] addr, input logic [4:0] len, input int ar_delay,
                           input int last_at, input int bad_at, input logic [1:0] bad_resp);
        logic [31:0] beats[$];
        int idx, cyc;
        for (int i = 0; i <= last_at; i++) beats.push_back($urandom());
        @(negedge clk);
        rd_req_addr = addr; rd_req_len = len; rd_req_valid = 1'b1;
        #1 check_eq("rd_req_ready_idle", rd_req_ready, 1);
        @(posedge clk); #1 rd_req_valid = 1'b0;
        for (int n = 0; n <= ar_delay; n++) begin
            @(negedge clk);
            ax.m_arready = (n == ar_delay);
            #1;
            check_eq("m_arvalid", ax.m_arvalid, 1);
            check_eq("m_araddr", ax.m_araddr, addr);
            check_eq("m_arlen", ax.m_arlen, {3'b000, len});
            check_eq("m_arsize", ax.m_arsize, 3'd2);
            check_eq("m_arburst", ax.m_arburst, 2'd1);
            check_eq("rd_req_ready_busy", rd_req_ready, 0);
        end
        idx = 0; cyc = 0;
        while (idx <= last_at && cyc < 300) begin
            @(negedge clk);
            ax.m_arready = 1'b0;
            ax.m_rvalid  = ($urandom_range(0, 3) != 0);
            ax.m_rdata   = beats[idx];
            ax.m_rlast   = (idx == last_at);
            ax.m_rresp   = (idx == bad_at) ? bad_resp : 2'b00;
            rd_ready     = ($urandom_range(0, 3) != 0);
            #1;
            if (cyc == 0) check_eq("m_arvalid_drop", ax.m_arvalid, 0);
            check_eq("rd_valid_pass", rd_valid, ax.m_rvalid);
            check_eq("rd_last_pass", rd_last, ax.m_rlast);
            check_eq("m_rready_pass", ax.m_rready, rd_ready);
            if (ax.m_rvalid && rd_ready) begin
                check_eq("rd_rdata", rd_rdata, beats[idx]);
                idx++;
            end
            cyc++;
        end
        check_eq("rd_beats", idx, last_at + 1);
        if (last_at != int'(len)) exp_err[2] = 1'b1;
        if (bad_at >= 0 && bad_at <= last_at && bad_resp != 2'b00) exp_err[0] = 1'b1;
        @(negedge clk);
        ax.m_rvalid = 1'b0; ax.m_rlast = 1'b0; ax.m_rresp = 2'b00; rd_ready = 1'b0;
        #1 check_eq("rd_idle_after", rd_req_ready, 1);
    endtask

    // One write burst of len+1 engine beats; wr_last is driven on beat wlast_at.
    task automatic do_write(input logic [31:0] addr, input logic [4:0] len, input int aw_delay,
                            input int wlast_at, input logic [1:0] bresp, input int b_delay,
                            input bit toggle, input bit clr_at_b);
        logic [31:0] beats[$];
        int idx, cyc;
        for (int i = 0; i <= int'(len); i++) beats.push_back($urandom());
        @(negedge clk);
        wr_req_addr = addr; wr_req_len = len; wr_req_valid = 1'b1;
        #1 check_eq("wr_req_ready_idle", wr_req_ready, 1);
        @(posedge clk); #1 wr_req_valid = 1'b0;
        for (int n = 0; n <= aw_delay; n++) begin
            @(negedge clk);
            ax.m_awready = (n == aw_delay);
            wr_valid = 1'b1; wr_data = beats[0]; wr_last = (wlast_at == 0); ax.m_wready = 1'b1;
            #1;
            check_eq("m_awvalid", ax.m_awvalid, 1);
            check_eq("m_awaddr", ax.m_awaddr, addr);
            check_eq("m_awlen", ax.m_awlen, {3'b000, len});
            check_eq("m_awsize", ax.m_awsize, 3'd2);
            check_eq("m_awburst", ax.m_awburst, 2'd1);
            check_eq("w_before_aw", ax.m_wvalid, 0);
            check_eq("wr_ready_in_aw", wr_ready, 0);
            check_eq("wr_req_ready_aw", wr_req_ready, 0);
        end
        idx = 0; cyc = 0;
        while (idx <= int'(len) && cyc < 300) begin
            @(negedge clk);
            ax.m_awready = 1'b0;
            wr_valid     = ($urandom_range(0, 3) != 0);
            wr_data      = beats[idx];
            wr_last      = (idx == wlast_at);
            ax.m_wready  = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            #1;
            if (cyc == 0) check_eq("m_awvalid_drop", ax.m_awvalid, 0);
            check_eq("m_wvalid_pass", ax.m_wvalid, wr_valid);
            check_eq("wr_ready_pass", wr_ready, ax.m_wready);
            check_eq("m_wstrb", ax.m_wstrb, 4'hF);
            check_eq("m_wlast", ax.m_wlast, (idx == int'(len)));
            check_eq("wr_req_ready_w", wr_req_ready, 0);
            check_eq("m_bready_w", ax.m_bready, 0);
            if (wr_valid && ax.m_wready) begin
                check_eq("m_wdata", ax.m_wdata, beats[idx]);
                if ((idx == wlast_at) != (idx == int'(len))) exp_err[2] = 1'b1;
                idx++;
            end
            cyc++;
        end
        check_eq("w_beats", idx, int'(len) + 1);
        for (int n = 0; n <= b_delay; n++) begin
            @(negedge clk);
            wr_valid = 1'b1; ax.m_wready = 1'b1;
            ax.m_bvalid = (n == b_delay); ax.m_bresp = bresp;
            err_clr = clr_at_b && (n == b_delay);
            #1;
            check_eq("m_bready", ax.m_bready, 1);
            check_eq("no_extra_w", ax.m_wvalid, 0);
            check_eq("wr_ready_resp", wr_ready, 0);
            check_eq("wr_req_ready_b", wr_req_ready, 0);
        end
        if (clr_at_b) exp_err = 4'b0000;
        if (bresp != 2'b00) exp_err[1] = 1'b1;
        @(negedge clk);
        ax.m_bvalid = 1'b0; ax.m_bresp = 2'b00; wr_valid = 1'b0; ax.m_wready = 1'b0; err_clr = 1'b0;
        #1;
        check_eq("wr_idle_after", wr_req_ready, 1);
        check_eq("m_bready_idle", ax.m_bready, 0);
    endtask

    task automatic pulse_clr();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        exp_err = 4'b0000;
        #1 check_eq("err_cleared", err_status, 4'b0000);
    endtask

    int rlen, wlen, last_at, wlast_at, bad_at;

    initial begin
        rst = 1'b1; err_clr = 1'b0; exp_err = 4'b0000;
        rd_req_addr = 32'h0; rd_req_len = 5'd0; rd_req_valid = 1'b0; rd_ready = 1'b0;
        wr_req_addr = 32'h0; wr_req_len = 5'd0; wr_req_valid = 1'b0;
        wr_data = 32'h0; wr_valid = 1'b0; wr_last = 1'b0;
        ax.m_arready = 1'b0; ax.m_rdata = 32'h0; ax.m_rresp = 2'b00; ax.m_rlast = 1'b0;
        ax.m_rvalid = 1'b1; ax.m_awready = 1'b0; ax.m_wready = 1'b0;
        ax.m_bresp = 2'b00; ax.m_bvalid = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_rd_req_ready", rd_req_ready, 0);
        check_eq("rst_wr_req_ready", wr_req_ready, 0);
        check_eq("rst_err", err_status, 4'b0000);
        check_eq("rst_arvalid", ax.m_arvalid, 0);
        check_eq("rst_awvalid", ax.m_awvalid, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        @(negedge clk); rst = 1'b0; ax.m_rvalid = 1'b0;
        #1;
        check_eq("post_rst_rd_req_ready", rd_req_ready, 1);
        check_eq("post_rst_wr_req_ready", wr_req_ready, 1);

        do_read(32'h0000_1000, 5'd7, 3, 7, -1, 2'b00);
        #1 check_eq("err_after_rd", err_status, exp_err);

        do_write(32'h0000_2000, 5'd2, 1, 2, 2'b00, 2, 1'b1, 1'b0);
        #1 check_eq("err_after_wr", err_status, exp_err);

        fork
            do_read(32'h0000_4000, 5'd7, 1, 7, -1, 2'b00);
            do_write(32'h0000_5000, 5'd7, 0, 7, 2'b00, 0, 1'b0, 1'b0);
        join
        #1 check_eq("err_after_concurrent", err_status, exp_err);

        do_read(32'h0000_6000, 5'd3, 0, 1, 0, 2'b10);
        #1 check_eq("err_rresp_len", err_status, 4'b0101);
        pulse_clr();

        do_read(32'h0000_6020, 5'd3, 0, 1, 0, 2'b10);
        do_write(32'h0000_7000, 5'd1, 0, 1, 2'b10, 1, 1'b0, 1'b1);
        #1 check_eq("err_clr_vs_event", err_status, 4'b0010);
        pulse_clr();

        // reset in the middle of a write data phase
        @(negedge clk); wr_req_addr = 32'h0000_3000; wr_req_len = 5'd3; wr_req_valid = 1'b1;
        @(posedge clk); #1 wr_req_valid = 1'b0;
        @(negedge clk); ax.m_awready = 1'b1;
        @(posedge clk); #1 ax.m_awready = 1'b0;
        @(negedge clk); wr_valid = 1'b1; wr_data = 32'hA5A5_0001; ax.m_wready = 1'b1;
        #1 check_eq("mid_w_wvalid", ax.m_wvalid, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        check_eq("rst_mid_wvalid", ax.m_wvalid, 0);
        check_eq("rst_mid_wready", wr_ready, 0);
        check_eq("rst_mid_wlast", ax.m_wlast, 0);
        check_eq("rst_mid_bready", ax.m_bready, 0);
        check_eq("rst_mid_wr_req_ready", wr_req_ready, 0);
        @(negedge clk); rst = 1'b0; wr_valid = 1'b0; ax.m_wready = 1'b0;
        #1 check_eq("rst_mid_idle", wr_req_ready, 1);
        do_write(32'h0000_3100, 5'd3, 0, 3, 2'b00, 0, 1'b0, 1'b0);
        #1 check_eq("err_after_rst_write", err_status, 4'b0000);

        for (int t = 0; t < 12; t++) begin
            rlen = $urandom_range(0, 7);
            wlen = $urandom_range(0, 7);
            case ($urandom_range(0, 5))
                0: last_at = (rlen > 0) ? rlen - 1 : rlen;
                1: last_at = rlen + 1;
                default: last_at = rlen;
            endcase
            wlast_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : wlen;
            bad_at   = $urandom_range(0, 15);
            fork
                do_read($urandom() & 32'hFFFF_FFE0, rlen[4:0], $urandom_range(0, 3), last_at,
                        bad_at, 2'($urandom_range(1, 3)));
                do_write($urandom() & 32'hFFFF_FFE0, wlen[4:0], $urandom_range(0, 3), wlast_at,
                         ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00, $urandom_range(0, 3),
                         1'b0, 1'b0);
            join
            #1 check_eq("rand_err", err_status, exp_err);
            pulse_clr();
        end

`ifdef BRIDGE_TIMEOUT_EN
        @(negedge clk); wr_req_addr = 32'h0000_8000; wr_req_len = 5'd0; wr_req_valid = 1'b1;
        @(posedge clk); #1 wr_req_valid = 1'b0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk); #1 check_eq("to_awvalid_hold", ax.m_awvalid, 1);
        end
        @(negedge clk); #1;
        check_eq("to_awvalid_drop", ax.m_awvalid, 0);
        check_eq("to_err3", err_status[3], 1);
        check_eq("to_wr_req_ready", wr_req_ready, 1);
        pulse_clr();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end
endmodule
